clk_div_arbiter: RTL and testbench

CLK_DIV_ARBITER -- requirements
Module: clk_div_arbiter

---
 rtl/clk_div_arbiter.sv | 153 +++++++++++++++
 tb/tb_clk_div_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_arbiter.sv
// ============================================================================
// Module   : clk_div_arbiter
// Purpose  : Round-robin owner arbitration for one shared clock divider.
//            A new period is applied only on a divider wrap or a timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_arbiter #(
    parameter logic [10:0] DEFAULT_PERIOD = 11'd4,
    parameter logic [15:0] WRAP_TIMEOUT   = 16'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [10:0] period0,
    input  logic [10:0] period1,
    input  logic [10:0] period2,
    input  logic        div_wrap,
    output logic [10:0] period,
    output logic [2:0]  grant,
    output logic [2:0]  ack,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARB       = 3'd1,
        S_WAIT_WRAP = 3'd2,
        S_OWNED     = 3'd3,
        S_RELEASE   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_owner;
    logic [1:0]  r_last;
    logic [10:0] r_pending;
    logic [10:0] r_period;
    logic [15:0] r_cnt;

    logic        w_found;
    logic [1:0]  w_winner;
    logic [10:0] w_sel_period;
    logic [10:0] w_clamped;
    logic        w_fire;
    logic [2:0]  w_owner_oh;

    // Search order starts just after the previous owner.
    function automatic logic [2:0] f_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] c;
        case (last)
            2'd0:    begin a = 2'd1; b = 2'd2; c = 2'd0; end
            2'd1:    begin a = 2'd2; b = 2'd0; c = 2'd1; end
            default: begin a = 2'd0; b = 2'd1; c = 2'd2; end
        endcase
        if (r[a])      return {1'b1, a};
        else if (r[b]) return {1'b1, b};
        else if (r[c]) return {1'b1, c};
        else           return 3'b000;
    endfunction

    assign {w_found, w_winner} = f_pick(req, r_last);

    always_comb begin
        case (w_winner)
            2'd0:    w_sel_period = period0;
            2'd1:    w_sel_period = period1;
            default: w_sel_period = period2;
        endcase
    end

    assign w_clamped  = (w_sel_period < 11'd2) ? 11'd2 : w_sel_period;
    assign w_owner_oh = 3'b001 << r_owner;
    assign w_fire     = (r_state == S_WAIT_WRAP) &&
                        (div_wrap || (r_cnt == WRAP_TIMEOUT - 16'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The new period is forwarded combinationally so it is visible in the ack cycle.
    always_comb begin
        w_state_nxt = r_state;
        grant       = 3'b000;
        ack         = 3'b000;
        period      = r_period;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (|req) w_state_nxt = S_ARB;
            end
            S_ARB: begin
                if (w_found) begin
                    grant       = 3'b001 << w_winner;
                    w_state_nxt = S_WAIT_WRAP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_WRAP: begin
                grant = w_owner_oh;
                if (w_fire) begin
                    ack         = w_owner_oh;
                    period      = r_pending;
                    w_state_nxt = S_OWNED;
                end
            end
            S_OWNED: begin
                grant = w_owner_oh;
                if (!req[r_owner]) w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                w_state_nxt = (|req) ? S_ARB : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner   <= 2'd0;
            r_last    <= 2'd2;
            r_pending <= DEFAULT_PERIOD;
            r_period  <= DEFAULT_PERIOD;
            r_cnt     <= 16'd0;
        end else begin
            if (r_state == S_ARB && w_found) begin
                r_owner   <= w_winner;
                r_pending <= w_clamped;
                r_cnt     <= 16'd0;
            end
            if (r_state == S_WAIT_WRAP) begin
                if (w_fire) r_period <= r_pending;
                else        r_cnt    <= r_cnt + 16'd1;
            end
            if (r_state == S_OWNED && !req[r_owner]) begin
                r_last <= r_owner;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_arbiter.sv
// ============================================================================
// Module   : tb_clk_div_arbiter
// Purpose  : Directed and random stimulus against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_clk_div_arbiter;

    localparam int WT = 4096;
    localparam int DP = 4;
    localparam int M_IDLE = 0, M_ARB = 1, M_WAIT = 2, M_OWN = 3, M_REL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [10:0] period0 = 11'd0, period1 = 11'd0, period2 = 11'd0;
    logic        div_wrap = 1'b0;
    logic [10:0] period;
    logic [2:0]  grant;
    logic [2:0]  ack;
    logic        busy;

    clk_div_arbiter #(
        .DEFAULT_PERIOD (11'd4),
        .WRAP_TIMEOUT   (16'd4096)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .period0  (period0),
        .period1  (period1),
        .period2  (period2),
        .div_wrap (div_wrap),
        .period   (period),
        .grant    (grant),
        .ack      (ack),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    int m_phase, m_owner, m_last, m_wait, m_pend, m_per;
    logic [2:0]  o_g, o_a;
    logic [10:0] o_p;

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int clamp2(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE;
        m_owner = 0;
        m_last  = 2;
        m_wait  = 0;
        m_pend  = DP;
        m_per   = DP;
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic step(input logic [2:0] r, input logic [10:0] p0, input logic [10:0] p1,
                        input logic [10:0] p2, input logic w);
        int win, idx, eg, ea, ep, eb;
        bit fire;
        int pin[3];
        @(negedge clk);
        req = r; period0 = p0; period1 = p1; period2 = p2; div_wrap = w;
        #1;
        pin[0] = p0; pin[1] = p1; pin[2] = p2;
        win = -1;
        for (int k = 1; k <= 3; k++) begin
            idx = (m_last + k) % 3;
            if (win < 0 && r[idx]) win = idx;
        end
        fire = (m_phase == M_WAIT) && (w || m_wait == WT - 1);
        eb = (m_phase != M_IDLE) ? 1 : 0;
        eg = 0; ea = 0; ep = m_per;
        if (m_phase == M_ARB && win >= 0) eg = 1 << win;
        if (m_phase == M_WAIT || m_phase == M_OWN) eg = 1 << m_owner;
        if (fire) begin
            ea = 1 << m_owner;
            ep = m_pend;
        end
        o_g = grant; o_a = ack; o_p = period;
        check_val("grant", grant, eg);
        check_val("ack", ack, ea);
        check_val("period", period, ep);
        check_val("busy", busy, eb);
        @(posedge clk);
        case (m_phase)
            M_IDLE: if (r != 0) m_phase = M_ARB;
            M_ARB: begin
                if (win < 0) m_phase = M_IDLE;
                else begin
                    m_owner = win;
                    m_pend  = clamp2(pin[win]);
                    m_wait  = 0;
                    m_phase = M_WAIT;
                end
            end
            M_WAIT: begin
                if (fire) begin
                    m_per   = m_pend;
                    m_phase = M_OWN;
                end else m_wait++;
            end
            M_OWN: begin
                if (!r[m_owner]) begin
                    m_last  = m_owner;
                    m_phase = M_REL;
                end
            end
            default: m_phase = (r != 0) ? M_ARB : M_IDLE;
        endcase
    endtask

    // Reset lands mid-cycle to exercise the asynchronous path.
    task automatic do_reset(input logic w);
        @(negedge clk);
        #2 rst = 1'b1;
        div_wrap = w;
        #1;
        check_val("rst_period", period, DP);
        check_val("rst_grant", grant, 0);
        check_val("rst_ack", ack, 0);
        check_val("rst_busy", busy, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        req = 3'b000; div_wrap = 1'b0; rst = 1'b0;
    endtask

    task automatic run_until_ack(input logic [2:0] r, input logic [10:0] p0, input logic [10:0] p1,
                                 input logic [10:0] p2, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step(r, p0, p1, p2, ($urandom % 3) == 0);
            if (o_a != 3'b000) seen = 1'b1;
        end
        check_val(tag, seen, 1);
    endtask

    function automatic logic [10:0] pick_period();
        return (($urandom % 4) == 0) ? 11'($urandom % 3) : 11'($urandom % 2048);
    endfunction

    initial begin
        int t;
        int nacks;
        logic [2:0] dropm;
        logic [2:0] rr;
        logic [10:0] rp0, rp1, rp2;
        int acks[4];
        int pers[4];
        int exp_g[4];
        int exp_p[4];
        bit seen;

        model_reset();
        do_reset(1'b0);

        // Single requester, wrap five cycles after grant
        step(3'b001, 11'd8, 11'd0, 11'd0, 1'b0);
        step(3'b001, 11'd8, 11'd0, 11'd0, 1'b0);
        check_val("basic_grant", o_g, 1);
        repeat (4) step(3'b001, 11'd8, 11'd0, 11'd0, 1'b0);
        step(3'b001, 11'd8, 11'd0, 11'd0, 1'b1);
        check_val("basic_ack", o_a, 1);
        check_val("basic_period", o_p, 8);

        // Round robin with all requesters active
        do_reset(1'b0);
        nacks = 0;
        dropm = 3'b000;
        for (int i = 0; i < 400 && nacks < 4; i++) begin
            step(3'b111 & ~dropm, 11'd3, 11'd5, 11'd7, ($urandom % 3) == 0);
            if (o_a != 3'b000) begin
                acks[nacks] = o_a;
                pers[nacks] = o_p;
                nacks++;
            end
            dropm = o_a;
        end
        exp_g = '{1, 2, 4, 1};
        exp_p = '{3, 5, 7, 3};
        check_val("rr_count", nacks, 4);
        for (int i = 0; i < 4; i++) begin
            check_val("rr_grant", (i < nacks) ? acks[i] : 0, exp_g[i]);
            check_val("rr_period", (i < nacks) ? pers[i] : 0, exp_p[i]);
        end

        // Zero period is clamped
        do_reset(1'b0);
        run_until_ack(3'b010, 11'd9, 11'd0, 11'd9, "clamp_seen");
        check_val("clamp_period", o_p, 2);
        check_val("clamp_ack", o_a, 2);

        // Timeout without any divider wrap
        do_reset(1'b0);
        step(3'b001, 11'd20, 11'd0, 11'd0, 1'b0);
        step(3'b001, 11'd20, 11'd0, 11'd0, 1'b0);
        t = 0;
        seen = 1'b0;
        for (int i = 0; i < WT + 10 && !seen; i++) begin
            step(3'b001, 11'd20, 11'd0, 11'd0, 1'b0);
            t++;
            if (o_a != 3'b000) seen = 1'b1;
        end
        check_val("timeout_latency", t, WT);
        check_val("timeout_period", o_p, 20);

        // Reset while an update is pending
        do_reset(1'b0);
        step(3'b001, 11'd9, 11'd0, 11'd0, 1'b0);
        step(3'b001, 11'd9, 11'd0, 11'd0, 1'b0);
        repeat (3) step(3'b001, 11'd9, 11'd0, 11'd0, 1'b0);
        do_reset(1'b1);
        step(3'b010, 11'd9, 11'd12, 11'd0, 1'b0);
        step(3'b010, 11'd9, 11'd12, 11'd0, 1'b0);
        check_val("post_rst_grant", o_g, 2);
        run_until_ack(3'b010, 11'd9, 11'd12, 11'd0, "post_rst_seen");
        check_val("post_rst_period", o_p, 12);

        // Owner is never preempted and its period changes are ignored
        do_reset(1'b0);
        run_until_ack(3'b001, 11'd6, 11'd11, 11'd0, "hold_seen");
        for (int i = 0; i < 5; i++) begin
            step(3'b011, 11'd10, 11'd11, 11'd0, ($urandom % 2) == 0);
            check_val("hold_grant", o_g, 1);
            check_val("hold_period", o_p, 6);
        end
        step(3'b010, 11'd10, 11'd11, 11'd0, 1'b0);
        check_val("drop_grant", o_g, 1);
        step(3'b010, 11'd10, 11'd11, 11'd0, 1'b0);
        check_val("release_grant", o_g, 0);
        check_val("release_period", o_p, 6);
        step(3'b010, 11'd10, 11'd11, 11'd0, 1'b0);
        check_val("next_grant", o_g, 2);

        // Random traffic
        do_reset(1'b0);
        rr = 3'b000;
        rp0 = pick_period(); rp1 = pick_period(); rp2 = pick_period();
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 3; b++) if (($urandom % 6) == 0) rr[b] = ~rr[b];
            if (($urandom % 10) == 0) rp0 = pick_period();
            if (($urandom % 10) == 0) rp1 = pick_period();
            if (($urandom % 10) == 0) rp2 = pick_period();
            if (($urandom % 500) == 0) do_reset(1'($urandom % 2));
            step(rr, rp0, rp1, rp2, ($urandom % 5) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
